// File: rtl/tl_pkg.sv
// Shared types, light encodings and default durations for the traffic-light sequencer.
// Optional pedestrian phase is enabled with LIGHT_SEQUENCER_PED_WALK_EN.
package tl_pkg;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    localparam int unsigned T_MAIN_GREEN_DEF = 10;
    localparam int unsigned T_SIDE_GREEN_DEF = 6;
    localparam int unsigned T_YELLOW_DEF     = 3;
    localparam int unsigned T_ALL_RED_DEF    = 1;
    localparam int unsigned T_WALK_DEF       = 5;

    typedef enum logic [2:0] {
        INIT,
        MAIN_G,
        MAIN_Y,
        RED_A,
        SIDE_G,
        SIDE_Y,
        RED_B
`ifdef LIGHT_SEQUENCER_PED_WALK_EN
        , WALK
`endif
    } tl_state_e;

    // Durations must fit the 4-bit timer load and be non-zero.
    function automatic logic dur_ok(input int unsigned d);
        dur_ok = (d >= 1) && (d <= 15);
    endfunction

endpackage

// File: rtl/tl_req_latch.sv
// Demand latch: set on any edge with i_set, cleared on any edge with i_clr.
// Clear wins when both are asserted on the same edge.
module tl_req_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic i_set,
    input  logic i_clr,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (i_clr) begin
            r_q <= 1'b0;
        end else if (i_set) begin
            r_q <= 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/light_sequencer.sv
// Two-road traffic-light sequencer driving an external one-shot timer.
// Define LIGHT_SEQUENCER_PED_WALK_EN to add the pedestrian WALK phase (ped_req/walk ports).
module light_sequencer
    import tl_pkg::*;
#(
    parameter int unsigned T_MAIN_GREEN = T_MAIN_GREEN_DEF,
    parameter int unsigned T_SIDE_GREEN = T_SIDE_GREEN_DEF,
    parameter int unsigned T_YELLOW     = T_YELLOW_DEF,
    parameter int unsigned T_ALL_RED    = T_ALL_RED_DEF
`ifdef LIGHT_SEQUENCER_PED_WALK_EN
    , parameter int unsigned T_WALK     = T_WALK_DEF
`endif
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic       car_side,
    input  logic       expired,
`ifdef LIGHT_SEQUENCER_PED_WALK_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [3:0] value,
    output logic       start_timer,
    output logic [2:0] main_light,
    output logic [2:0] side_light
);

    if (!dur_ok(T_MAIN_GREEN) || !dur_ok(T_SIDE_GREEN) ||
        !dur_ok(T_YELLOW) || !dur_ok(T_ALL_RED)
`ifdef LIGHT_SEQUENCER_PED_WALK_EN
        || !dur_ok(T_WALK)
`endif
       ) begin : g_bad_duration
        $error("light_sequencer: duration parameters must lie in 1..15");
    end

    tl_state_e  r_state;
    tl_state_e  w_next;
    logic       w_arm;
    logic [3:0] w_dur;
    logic [3:0] r_value;
    logic       r_start;
    logic       w_car_q;
    logic       w_demand;

    function automatic logic [3:0] dur_of(input tl_state_e s);
        case (s)
            MAIN_G:         dur_of = 4'(T_MAIN_GREEN);
            MAIN_Y, SIDE_Y: dur_of = 4'(T_YELLOW);
            SIDE_G:         dur_of = 4'(T_SIDE_GREEN);
`ifdef LIGHT_SEQUENCER_PED_WALK_EN
            WALK:           dur_of = 4'(T_WALK);
`endif
            default:        dur_of = 4'(T_ALL_RED);
        endcase
    endfunction

    tl_req_latch u_car_latch (
        .clk   (clk1),
        .rst_n (rst_n),
        .i_set (car_side),
        .i_clr (w_arm && (w_next == SIDE_G)),
        .o_q   (w_car_q)
    );

`ifdef LIGHT_SEQUENCER_PED_WALK_EN
    logic w_ped_q;

    tl_req_latch u_ped_latch (
        .clk   (clk1),
        .rst_n (rst_n),
        .i_set (ped_req),
        .i_clr (w_arm && (w_next == WALK)),
        .o_q   (w_ped_q)
    );

    assign w_demand = w_car_q | w_ped_q;
`else
    assign w_demand = w_car_q;
`endif

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_start <= 1'b0;
            r_value <= '0;
        end else begin
            r_state <= w_next;
            r_start <= w_arm;
            if (w_arm) begin
                r_value <= w_dur;
            end
        end
    end

    // r_start marks the arm cycle; an expiry seen then belongs to the previous timer run.
    always_comb begin
        w_next = r_state;
        w_arm  = 1'b0;
        if (r_state == INIT) begin
            w_next = RED_B;
            w_arm  = 1'b1;
        end else if (expired && !r_start) begin
            w_arm = 1'b1;
            case (r_state)
                MAIN_G:  w_next = w_demand ? MAIN_Y : MAIN_G;
                MAIN_Y:  w_next = RED_A;
`ifdef LIGHT_SEQUENCER_PED_WALK_EN
                RED_A:   w_next = w_ped_q ? WALK : SIDE_G;
                WALK:    w_next = w_car_q ? SIDE_G : RED_B;
`else
                RED_A:   w_next = SIDE_G;
`endif
                SIDE_G:  w_next = SIDE_Y;
                SIDE_Y:  w_next = RED_B;
                RED_B:   w_next = MAIN_G;
                default: w_next = RED_B;
            endcase
        end
        w_dur = dur_of(w_next);
    end

    always_comb begin
        main_light = LIGHT_R;
        side_light = LIGHT_R;
`ifdef LIGHT_SEQUENCER_PED_WALK_EN
        walk       = (r_state == WALK);
`endif
        case (r_state)
            MAIN_G:  main_light = LIGHT_G;
            MAIN_Y:  main_light = LIGHT_Y;
            SIDE_G:  side_light = LIGHT_G;
            SIDE_Y:  side_light = LIGHT_Y;
            default: ;
        endcase
    end

    assign value       = r_value;
    assign start_timer = r_start;

endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 SHALL have parameter T_MAIN_GREEN, default 10, main-road green duration in timer ticks.
REQ-002 SHALL have parameter T_SIDE_GREEN, default 6, side-road green duration.
REQ-003 SHALL have parameter T_YELLOW, default 3, yellow duration for either road.
REQ-004 SHALL have parameter T_ALL_RED, default 1, all-red clearance duration.
REQ-005 SHALL have port clk1, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-007 SHALL have port car_side, input, 1, side-road vehicle sensor level.
REQ-008 SHALL have port expired, input, 1, one-cycle pulse from the downstream timer, sampled at the rising edge of clk1.
REQ-009 SHALL have port value, output, 4, duration loaded into the timer.
REQ-010 SHALL have port start_timer, output, 1, timer arm pulse; the timer arms on its falling edge.
REQ-011 SHALL have port main_light, output, 3, one-hot {R,Y,G}.
REQ-012 SHALL have port side_light, output, 3, one-hot {R,Y,G}.

Function
REQ-013 SHALL implement states INIT, MAIN_G, MAIN_Y, RED_A, SIDE_G, SIDE_Y, RED_B.
REQ-014 SHALL sequence MAIN_G->MAIN_Y->RED_A->SIDE_G->SIDE_Y->RED_B->MAIN_G; each step occurs on the edge where expired==1.
REQ-015 SHALL leave INIT on the first edge after reset release and enter RED_B unconditionally.
REQ-016 SHALL leave MAIN_G on expired only when the demand latch car_q==1; otherwise it SHALL stay in MAIN_G and re-arm the timer with T_MAIN_GREEN.
REQ-017 SHALL set car_q on any edge where car_side==1, and SHALL clear it on the edge entering SIDE_G; on that edge, clear SHALL take priority over set.
REQ-018 SHALL update value and assert start_timer on the same edge that enters or re-arms a state; start_timer SHALL be high for exactly one cycle.
REQ-019 SHALL hold value stable from the arm pulse until the next arm pulse.
REQ-020 SHALL drive lights from registered state as follows: MAIN_G=G/R, MAIN_Y=Y/R, SIDE_G=R/G, SIDE_Y=R/Y, all others R/R (main/side).
REQ-021 SHALL NOT drive both lights non-red in any cycle.
REQ-022 SHALL ignore expired while in INIT and in the arm cycle itself.
REQ-023 SHALL reject at elaboration any duration parameter outside 1..15.

Reset
REQ-024 SHALL, while rst_n==0, hold state=INIT, car_q=0, value=0, start_timer=0, main_light=side_light=R.
REQ-025 SHALL abort any sequence on reset assertion mid-operation, with no pending arm pulse surviving reset.

Configuration
REQ-026 SHALL support macro LIGHT_SEQUENCER_PED_WALK_EN; when defined, it SHALL add input ped_req, output walk, parameter T_WALK (default 5), state WALK, and latch ped_q using the same set/clear rules as car_q, cleared on entering WALK.
REQ-027 SHALL, with LIGHT_SEQUENCER_PED_WALK_EN defined, use car_q|ped_q as the MAIN_G exit demand; RED_A SHALL go to WALK if ped_q, else to SIDE_G; WALK SHALL go to SIDE_G if car_q, else to RED_B; walk=1 only in WALK, with both lights R.
REQ-028 SHALL, without LIGHT_SEQUENCER_PED_WALK_EN, have no ped_req or walk ports and no WALK state, with behaviour per REQ-013..023.

Structure
REQ-029 SHALL take the state enum, light encodings (R=3'b100, Y=3'b010, G=3'b001) and default durations from shared package tl_pkg.
REQ-030 SHALL place demand latching in one sub-module, tl_req_latch (set, clear, priority per REQ-017), instantiated once per request.

Verification
REQ-031 SHALL cover reset release: first edge -> INIT->RED_B, value=1, one start_timer pulse; lights R/R.
REQ-032 SHALL cover no demand: car_side=0, expired every arm -> MAIN_G held, value=10 re-armed each expiry.
REQ-033 SHALL cover a demand pulse: car_side high for 1 cycle during MAIN_G -> next expired gives MAIN_Y (value=3), then RED_A (1), SIDE_G (6), SIDE_Y (3), RED_B (1), MAIN_G.
REQ-034 SHALL cover a collision: car_side=1 on the edge entering SIDE_G -> car_q=0 afterward, and the next MAIN_G expiry re-arms MAIN_G.
REQ-035 SHALL cover mid-sequence reset: rst_n low in SIDE_G -> immediate R/R, start_timer=0, value=0; recovery per REQ-031.
REQ-036 SHALL cover walk, with LIGHT_SEQUENCER_PED_WALK_EN: ped_req pulse only -> MAIN_Y, RED_A, WALK (value=5, walk=1), RED_B, MAIN_G; SIDE_G skipped.
